// File: rtl/msx_mouse_reader.sv
// msx_mouse_reader
//   Host-side initiator for the MSX mouse strobe protocol on a joystick port.
//   Each read toggles the strobe line four times. One data nibble is sampled
//   SETTLE cycles after each toggle. The nibbles are assembled into signed X/Y
//   deltas, and the button states are captured alongside them.
//
//   After reset the block waits RESYNC idle cycles before it accepts a read.
//   That wait is long enough for the device's nibble index to time out to 0
//   after an aborted sequence.
//
// Parameters
//   SETTLE  cycles from each strobe toggle to its nibble sample (>= 3)
//   RESYNC  idle cycles after reset before the first read
//
// Ports
//   clk_sys  in   system clock
//   reset    in   synchronous, active-high reset
//   start    in   request one read; ignored while busy
//   pins     in   joystick port inputs: [3:0] data nibble (bit3 = MSB),
//                 [5:4] buttons 2/1 (active-low)
//   strobe   out  port strobe line (pin 8) to the device
//   busy     out  high during resync or a read
//   valid    out  one-cycle pulse when dx/dy/btn are updated
//   dx, dy   out  X/Y deltas, two's complement, as sent by the device
//   btn      out  buttons, active-high: [0] = pins[4], [1] = pins[5]
//   pos_x,   out  (only with MSX_MOUSE_ACCUM_EN) saturating 16-bit unsigned
//   pos_y         position accumulators, reset to 16'h8000
//
// Build option
//   MSX_MOUSE_ACCUM_EN  when defined, adds the pos_x/pos_y accumulators
//
// States
//   ST_RESYNC | post-reset wait, start ignored
//   ST_IDLE   | waiting for start
//   ST_SETTLE | counting down to the next nibble sample
//   ST_DONE   | publish dx/dy/btn, pulse valid

module msx_mouse_reader #(
  parameter int SETTLE = 64,
  parameter int RESYNC = 131072
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] pins,
  output logic       strobe,
  output logic       busy,
  output logic       valid,
  output logic [7:0] dx,
  output logic [7:0] dy,
  output logic [1:0] btn
`ifdef MSX_MOUSE_ACCUM_EN
  ,
  output logic [15:0] pos_x,
  output logic [15:0] pos_y
`endif
);

  localparam int RW = $clog2(RESYNC) + 1;
  localparam int SW = $clog2(SETTLE) + 1;

  typedef enum logic [1:0] {
    ST_RESYNC,
    ST_IDLE,
    ST_SETTLE,
    ST_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   rs_cnt_q, rs_cnt_d;
  logic [SW-1:0]   st_cnt_q, st_cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic            strobe_q, strobe_d;
  logic            busy_q, busy_d;
  logic            valid_q, valid_d;
  logic [7:0]      x_q, x_d;
  logic [7:0]      y_q, y_d;
  logic [1:0]      bcap_q, bcap_d;
  logic [7:0]      dx_q, dx_d;
  logic [7:0]      dy_q, dy_d;
  logic [1:0]      btn_q, btn_d;
  logic [5:0]      pins_m_q, pins_s_q;

`ifdef MSX_MOUSE_ACCUM_EN
  logic [15:0] pos_x_q, pos_x_d;
  logic [15:0] pos_y_q, pos_y_d;
  logic [17:0] px_sum, py_sum;

  // Clamp an 18-bit result of a 16-bit unsigned +/- 8-bit signed operation.
  // A set bit 17 means the result went negative. A set bit 16 means it
  // overflowed above 16'hFFFF.
  function automatic logic [15:0] sat16(input logic [17:0] v);
    if (v[17])      return 16'h0000;
    else if (v[16]) return 16'hFFFF;
    else            return v[15:0];
  endfunction

  // MSX X motion is positive to the left, so it is subtracted.
  always_comb begin
    px_sum = {2'b00, pos_x_q} - {{10{x_q[7]}}, x_q};
    py_sum = {2'b00, pos_y_q} + {{10{y_q[7]}}, y_q};
  end
`endif

  always_comb begin
    state_d  = state_q;
    rs_cnt_d = rs_cnt_q;
    st_cnt_d = st_cnt_q;
    idx_d    = idx_q;
    strobe_d = strobe_q;
    busy_d   = busy_q;
    valid_d  = 1'b0;
    x_d      = x_q;
    y_d      = y_q;
    bcap_d   = bcap_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    btn_d    = btn_q;
`ifdef MSX_MOUSE_ACCUM_EN
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
`endif

    case (state_q)
      ST_RESYNC: begin
        if (rs_cnt_q == '0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          rs_cnt_d = rs_cnt_q - RW'(1);
        end
      end

      ST_IDLE: begin
        if (start) begin
          strobe_d = ~strobe_q;
          st_cnt_d = SW'(SETTLE - 1);
          idx_d    = 2'd0;
          busy_d   = 1'b1;
          state_d  = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (st_cnt_q == '0) begin
          case (idx_q)
            2'd0: x_d[7:4] = pins_s_q[3:0];
            2'd1: x_d[3:0] = pins_s_q[3:0];
            2'd2: y_d[7:4] = pins_s_q[3:0];
            2'd3: y_d[3:0] = pins_s_q[3:0];
            default: ;
          endcase
          if (idx_q == 2'd3) begin
            // The last nibble gets no toggle, so each read makes exactly four edges.
            bcap_d  = ~pins_s_q[5:4];
            state_d = ST_DONE;
          end else begin
            strobe_d = ~strobe_q;
            st_cnt_d = SW'(SETTLE - 1);
            idx_d    = idx_q + 2'd1;
          end
        end else begin
          st_cnt_d = st_cnt_q - SW'(1);
        end
      end

      ST_DONE: begin
        dx_d    = x_q;
        dy_d    = y_q;
        btn_d   = bcap_q;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
`ifdef MSX_MOUSE_ACCUM_EN
        pos_x_d = sat16(px_sum);
        pos_y_d = sat16(py_sum);
`endif
      end

      default: begin
        state_d = ST_RESYNC;
        busy_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q  <= ST_RESYNC;
      rs_cnt_q <= RW'(RESYNC);
      st_cnt_q <= '0;
      idx_q    <= '0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b1;
      valid_q  <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      bcap_q   <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      btn_q    <= '0;
      pins_m_q <= 6'h3F;
      pins_s_q <= 6'h3F;
`ifdef MSX_MOUSE_ACCUM_EN
      pos_x_q  <= 16'h8000;
      pos_y_q  <= 16'h8000;
`endif
    end else begin
      state_q  <= state_d;
      rs_cnt_q <= rs_cnt_d;
      st_cnt_q <= st_cnt_d;
      idx_q    <= idx_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      x_q      <= x_d;
      y_q      <= y_d;
      bcap_q   <= bcap_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      btn_q    <= btn_d;
      pins_m_q <= pins;
      pins_s_q <= pins_m_q;
`ifdef MSX_MOUSE_ACCUM_EN
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
`endif
    end
  end

  assign strobe = strobe_q;
  assign busy   = busy_q;
  assign valid  = valid_q;
  assign dx     = dx_q;
  assign dy     = dy_q;
  assign btn    = btn_q;
`ifdef MSX_MOUSE_ACCUM_EN
  assign pos_x  = pos_x_q;
  assign pos_y  = pos_y_q;
`endif

endmodule

// File: tb/tb_msx_mouse_reader.sv
module tb_msx_mouse_reader;

  localparam int SETTLE  = 8;
  localparam int RESYNC  = 100;
  localparam int TIMEOUT = 80;   // responder's idle reset, shorter than RESYNC
  localparam int LAT     = 4 * SETTLE + 1;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       start;
  logic [5:0] pins;
  logic       strobe, busy, valid;
  logic [7:0] dx, dy;
  logic [1:0] btn;
`ifdef MSX_MOUSE_ACCUM_EN
  logic [15:0] pos_x, pos_y;
`endif

  always #5 clk_sys = ~clk_sys;

  msx_mouse_reader #(.SETTLE(SETTLE), .RESYNC(RESYNC)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .start   (start),
    .pins    (pins),
    .strobe  (strobe),
    .busy    (busy),
    .valid   (valid),
    .dx      (dx),
    .dy      (dy),
    .btn     (btn)
`ifdef MSX_MOUSE_ACCUM_EN
    ,
    .pos_x   (pos_x),
    .pos_y   (pos_y)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Responder model: presents the next nibble after each strobe edge, and
  // returns its index to 0 after TIMEOUT idle cycles.
  logic [7:0] rx = 8'h00, ry = 8'h00;
  logic [1:0] rb = 2'b11;
  logic [1:0] ptr = 2'd0;
  logic [3:0] nib = 4'hF;
  logic       s_prev = 1'b0;
  int         idle = 0;

  always @(posedge clk_sys) begin
    s_prev <= strobe;
    if (strobe != s_prev) begin
      case (ptr)
        2'd0: nib <= rx[7:4];
        2'd1: nib <= rx[3:0];
        2'd2: nib <= ry[7:4];
        default: nib <= ry[3:0];
      endcase
      ptr  <= ptr + 2'd1;
      idle <= 0;
    end else if (idle >= TIMEOUT) begin
      ptr <= 2'd0;
    end else begin
      idle <= idle + 1;
    end
  end

  assign pins = {rb, nib};

  // Scoreboard: expected results are pushed when a read is launched.
  typedef struct packed {
    logic [7:0] dx;
    logic [7:0] dy;
    logic [1:0] btn;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always @(negedge clk_sys) begin
    if (valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got dx=%0h dy=%0h with no read pending", dx, dy);
      end else begin
        mon_e = sb.pop_front();
        chk("dx", {24'd0, dx}, {24'd0, mon_e.dx});
        chk("dy", {24'd0, dy}, {24'd0, mon_e.dy});
        chk("btn", {30'd0, btn}, {30'd0, mon_e.btn});
      end
    end
  end

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic [1:0] b;
    logic [7:0] ex;
    logic [7:0] ey;
    logic [1:0] eb;
  } vec_t;
  vec_t vecs[5];

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin
      @(negedge clk_sys);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_wait: got busy=1 expected busy=0 within 400 cycles");
    end
  endtask

  // One complete read. Checks edge count and spacing, valid latency and pulse
  // count. Optionally pulses start while busy, which must have no effect.
  task automatic do_read(input logic [7:0] x, input logic [7:0] y, input logic [1:0] b,
                         input logic [7:0] ex, input logic [7:0] ey, input logic [1:0] eb,
                         input bit poke);
    int   ecnt, vcnt, vk;
    bit   pos_ok;
    logic sp;
    rx = x; ry = y; rb = b;
    wait_idle();
    sb.push_back({ex, ey, eb});
    sp = strobe;
    start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    ecnt = 0; vcnt = 0; vk = -1; pos_ok = 1'b1;
    for (int kk = 0; kk <= 40; kk++) begin
      if (kk > 0) @(negedge clk_sys);
      if (poke && kk == 5) start = 1'b1;
      if (poke && kk == 6) start = 1'b0;
      if (strobe != sp) begin
        if (kk != ecnt * SETTLE) pos_ok = 1'b0;
        ecnt++;
        sp = strobe;
      end
      if (valid) begin
        vcnt++;
        vk = kk;
      end
    end
    chk("edge_count", ecnt, 4);
    chk("edge_spacing", {31'd0, pos_ok}, 32'd1);
    chk("valid_count", vcnt, 1);
    chk("valid_latency", vk, LAT);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int   ecnt, v1, v2, e4k, n;
    bit   hold_ok;
    logic sp;

    vecs[0] = '{x: 8'hFD, y: 8'h05, b: 2'b10, ex: 8'hFD, ey: 8'h05, eb: 2'b01};
    vecs[1] = '{x: 8'h80, y: 8'h7F, b: 2'b01, ex: 8'h80, ey: 8'h7F, eb: 2'b10};
    vecs[2] = '{x: 8'h00, y: 8'h00, b: 2'b11, ex: 8'h00, ey: 8'h00, eb: 2'b00};
    vecs[3] = '{x: 8'hFF, y: 8'hFF, b: 2'b00, ex: 8'hFF, ey: 8'hFF, eb: 2'b11};
    vecs[4] = '{x: 8'h5A, y: 8'hA5, b: 2'b10, ex: 8'h5A, ey: 8'hA5, eb: 2'b01};

    reset = 1'b1;
    start = 1'b0;
    rx = 8'hFD; ry = 8'h05; rb = 2'b10;
    repeat (3) @(negedge clk_sys);
    chk("rst_strobe", {31'd0, strobe}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_dx", {24'd0, dx}, 32'd0);
    chk("rst_dy", {24'd0, dy}, 32'd0);
    chk("rst_btn", {30'd0, btn}, 32'd0);

    // start held high right after reset release: ignored during resync.
    reset = 1'b0;
    sb.push_back({8'hFD, 8'h05, 2'b01});
    hold_ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_sys);
      if (i == 0) start = 1'b1;
      if (!busy || strobe) hold_ok = 1'b0;
    end
    chk("resync_hold", {31'd0, hold_ok}, 32'd1);
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk_sys);
      n++;
    end
    chk("resync_busy_fall", {31'd0, busy}, 32'd0);
    chk("resync_no_toggle", {31'd0, strobe}, 32'd0);
    @(negedge clk_sys);
    chk("first_toggle", {31'd0, strobe}, 32'd1);
    chk("first_busy", {31'd0, busy}, 32'd1);
    start = 1'b0;
    wait_idle();

    for (int i = 0; i < 5; i++)
      do_read(vecs[i].x, vecs[i].y, vecs[i].b, vecs[i].ex, vecs[i].ey, vecs[i].eb, i == 1);

    // Back-to-back reads with start held: the second starts right after valid.
    rx = 8'h12; ry = 8'h34; rb = 2'b11;
    wait_idle();
    sb.push_back({8'h12, 8'h34, 2'b00});
    sp = strobe;
    start = 1'b1;
    @(negedge clk_sys);
    ecnt = 0; v1 = -1; v2 = -1; e4k = -1;
    for (int kk = 0; kk <= 80; kk++) begin
      if (kk > 0) @(negedge clk_sys);
      if (kk == 30) begin
        rx = 8'h80; ry = 8'h7F; rb = 2'b01;
        sb.push_back({8'h80, 8'h7F, 2'b10});
      end
      if (kk == 34) start = 1'b0;
      if (strobe != sp) begin
        if (ecnt == 4) e4k = kk;
        ecnt++;
        sp = strobe;
      end
      if (valid) begin
        if (v1 < 0) v1 = kk;
        else v2 = kk;
      end
    end
    chk("b2b_edges", ecnt, 8);
    chk("b2b_valid1", v1, LAT);
    chk("b2b_second_start", e4k, LAT + 1);
    chk("b2b_valid2", v2, 2 * LAT + 1);

    // Reset after the second toggle, then a clean read after the resync wait.
    rx = 8'hAA; ry = 8'h55; rb = 2'b11;
    wait_idle();
    sp = strobe;
    start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    ecnt = (strobe != sp) ? 1 : 0;
    sp = strobe;
    n = 0;
    while (ecnt < 2 && n < 20) begin
      @(negedge clk_sys);
      n++;
      if (strobe != sp) begin
        ecnt++;
        sp = strobe;
      end
    end
    chk("abort_edges", ecnt, 2);
    reset = 1'b1;
    @(negedge clk_sys);
    chk("abort_strobe", {31'd0, strobe}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd1);
    chk("abort_valid", {31'd0, valid}, 32'd0);
    chk("abort_dx", {24'd0, dx}, 32'd0);
    reset = 1'b0;
    do_read(8'h3C, 8'hC3, 2'b00, 8'h3C, 8'hC3, 2'b11, 1'b0);

`ifdef MSX_MOUSE_ACCUM_EN
    reset = 1'b1;
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    chk("pos_x_rst", {16'd0, pos_x}, 32'h8000);
    chk("pos_y_rst", {16'd0, pos_y}, 32'h8000);
    // 0x8000 - 257*127 - 126 = 3 ; 0x8000 + 257*127 + 113 = 0xFFF0
    for (int i = 0; i < 257; i++)
      do_read(8'h7F, 8'h7F, 2'b11, 8'h7F, 8'h7F, 2'b00, 1'b0);
    do_read(8'h7E, 8'h71, 2'b11, 8'h7E, 8'h71, 2'b00, 1'b0);
    chk("pos_x_pre", {16'd0, pos_x}, 32'h0003);
    chk("pos_y_pre", {16'd0, pos_y}, 32'hFFF0);
    do_read(8'h05, 8'h7F, 2'b11, 8'h05, 8'h7F, 2'b00, 1'b0);
    chk("pos_x_sat", {16'd0, pos_x}, 32'h0000);
    chk("pos_y_sat", {16'd0, pos_y}, 32'hFFFF);
`endif

    repeat (5) @(negedge clk_sys);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
